spi_conf_bank: RTL and testbench

Parametrised configuration register bank for the SPI controller, the successor to the fixed three-register configuration block. It holds NUM_CONF independently handshaken configuration words with per-register reset values and write masks. It adds an optional shadow/commit mode and a per-register update pulse. It also generates a soft-reset pulse of programmable length from a trigger bit in one register.

---
 rtl/spi_conf_bank.sv | 118 +++++++++++
 tb/tb_spi_conf_bank.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_conf_bank.sv
// spi_conf_bank
//   Configuration register bank for the SPI controller. NUM_CONF independent
//   configuration words, each loaded through its own valid/ready handshake,
//   with per-register reset values and write masks, an optional shadow/commit
//   stage, a per-register update pulse and a programmable-length soft-reset
//   pulse triggered by one bit of one register.
//
// Ports
//   clock        : rising-edge clock
//   reset_n      : asynchronous active-low reset
//   conf_valid   : [NUM_CONF]   per-register write request
//   conf_ready   : [NUM_CONF]   per-register write acknowledge
//   conf_in      : [NUM_CONF*CONFIG_WIDTH] write data, register i at [i*W +: W]
//   conf_out     : [NUM_CONF*CONFIG_WIDTH] active configuration words
//   conf_update  : [NUM_CONF]   one-cycle pulse when a conf_out word is loaded
//   commit       : apply pending shadows (COMMIT_MODE=1 only)
//   pending      : [NUM_CONF]   shadow holds an uncommitted write
//   soft_reset   : soft-reset pulse, SOFT_RESET_LEN cycles wide
module spi_conf_bank #(
    parameter int unsigned CONFIG_WIDTH   = 32,
    parameter int unsigned NUM_CONF       = 4,
    parameter logic [NUM_CONF*CONFIG_WIDTH-1:0] RESET_VALUES = '0,
    parameter logic [NUM_CONF*CONFIG_WIDTH-1:0] WRITE_MASK   = '1,
    parameter int unsigned COMMIT_MODE    = 0,
    parameter int unsigned SOFT_RESET_REG = 0,
    parameter int unsigned SOFT_RESET_BIT = 10,
    parameter int unsigned SOFT_RESET_LEN = 65535
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [NUM_CONF-1:0]              conf_valid,
    output logic [NUM_CONF-1:0]              conf_ready,
    input  logic [NUM_CONF*CONFIG_WIDTH-1:0] conf_in,
    output logic [NUM_CONF*CONFIG_WIDTH-1:0] conf_out,
    output logic [NUM_CONF-1:0]              conf_update,
    input  logic                             commit,
    output logic [NUM_CONF-1:0]              pending,
    output logic                             soft_reset
);

    localparam int unsigned CNT_W    = $clog2(SOFT_RESET_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(SOFT_RESET_LEN);
    localparam int unsigned TRIG_POS = SOFT_RESET_REG * CONFIG_WIDTH + SOFT_RESET_BIT;

    logic [NUM_CONF-1:0]              transfer;
    logic [NUM_CONF*CONFIG_WIDTH-1:0] store_val;
    logic [NUM_CONF*CONFIG_WIDTH-1:0] shadow;
    logic                             trigger;
    logic                             commit_en;
    logic [CNT_W-1:0]                 sr_count;

    always_comb begin
        transfer  = conf_valid & conf_ready;
        // Read-only bits always carry their reset value; the trigger bit is
        // self-clearing, so it is never stored.
        store_val = (conf_in & WRITE_MASK) | (RESET_VALUES & ~WRITE_MASK);
        store_val[TRIG_POS] = 1'b0;
        trigger   = transfer[SOFT_RESET_REG] & conf_in[TRIG_POS];
        commit_en = (COMMIT_MODE != 0) && commit;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conf_ready  <= '0;
            conf_update <= '0;
            pending     <= '0;
            soft_reset  <= 1'b0;
            sr_count    <= '0;
            conf_out    <= RESET_VALUES;
            shadow      <= RESET_VALUES;
        end else begin
            for (int unsigned i = 0; i < NUM_CONF; i++) begin
                // Ready is also cleared on the trigger edge so that it is
                // already low in the first soft-reset cycle; transfers on the
                // trigger edge itself still use the pre-edge ready.
                if (soft_reset || trigger || transfer[i]) begin
                    conf_ready[i] <= 1'b0;
                end else if (conf_valid[i]) begin
                    conf_ready[i] <= 1'b1;
                end

                conf_update[i] <= 1'b0;

                if (COMMIT_MODE == 0) begin
                    if (transfer[i]) begin
                        conf_out[i*CONFIG_WIDTH +: CONFIG_WIDTH] <= store_val[i*CONFIG_WIDTH +: CONFIG_WIDTH];
                        conf_update[i] <= 1'b1;
                    end
                end else begin
                    // Commit copies the pre-edge shadow; a write on the same
                    // edge lands in the shadow and re-arms pending afterwards.
                    if (commit_en && pending[i]) begin
                        conf_out[i*CONFIG_WIDTH +: CONFIG_WIDTH] <= shadow[i*CONFIG_WIDTH +: CONFIG_WIDTH];
                        conf_update[i] <= 1'b1;
                        pending[i]     <= 1'b0;
                    end
                    if (transfer[i]) begin
                        shadow[i*CONFIG_WIDTH +: CONFIG_WIDTH] <= store_val[i*CONFIG_WIDTH +: CONFIG_WIDTH];
                        pending[i] <= 1'b1;
                    end
                end
            end

            if (trigger) begin
                soft_reset <= 1'b1;
                sr_count   <= CNT_W'(1);
            end else if (soft_reset) begin
                if (sr_count == LEN_C) begin
                    soft_reset <= 1'b0;
                    sr_count   <= '0;
                end else begin
                    sr_count <= sr_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_conf_bank.sv
module tb_spi_conf_bank;

    localparam logic [127:0] RV_P = {32'h0000_0000, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000};
    localparam logic [127:0] WM_P = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_04FF};
    localparam int SR_LEN = 5;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic [3:0]   valid = '0;
    logic [127:0] cin = '0;
    logic         commit = 1'b0;

    logic [3:0]   ready0, upd0, pend0, ready1, upd1, pend1;
    logic [127:0] out0, out1;
    logic         sr0, sr1;

    always #5 clock = ~clock;

    spi_conf_bank #(
        .CONFIG_WIDTH(32), .NUM_CONF(4), .RESET_VALUES(RV_P), .WRITE_MASK(WM_P),
        .COMMIT_MODE(0), .SOFT_RESET_REG(0), .SOFT_RESET_BIT(10), .SOFT_RESET_LEN(SR_LEN)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .conf_valid(valid), .conf_ready(ready0),
        .conf_in(cin), .conf_out(out0), .conf_update(upd0), .commit(commit),
        .pending(pend0), .soft_reset(sr0)
    );

    spi_conf_bank #(
        .CONFIG_WIDTH(32), .NUM_CONF(4), .RESET_VALUES(RV_P), .WRITE_MASK(WM_P),
        .COMMIT_MODE(1), .SOFT_RESET_REG(0), .SOFT_RESET_BIT(10), .SOFT_RESET_LEN(SR_LEN)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .conf_valid(valid), .conf_ready(ready1),
        .conf_in(cin), .conf_out(out1), .conf_update(upd1), .commit(commit),
        .pending(pend1), .soft_reset(sr1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: words, shadows, pending flags and remaining soft-reset cycles.
    logic [127:0] rv_v, wm_v;
    logic [127:0] m_out0, m_out1, m_shadow;
    logic [3:0]   m_ready, m_pend, m_upd0, m_upd1;
    int           m_sr_left;

    typedef struct {
        int          ch;
        logic [31:0] data;
        logic [31:0] expect_word;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out0 = rv_v; m_out1 = rv_v; m_shadow = rv_v;
        m_ready = '0; m_pend = '0; m_upd0 = '0; m_upd1 = '0;
        m_sr_left = 0;
    endtask

    function automatic logic [31:0] stored(input int ch, input logic [31:0] d);
        logic [31:0] w;
        w = (d & wm_v[ch*32 +: 32]) | (rv_v[ch*32 +: 32] & ~wm_v[ch*32 +: 32]);
        if (ch == 0) w[10] = 1'b0;
        return w;
    endfunction

    task automatic model_step();
        logic [3:0]   xfer;
        logic         trig;
        logic         in_sr;
        logic [127:0] old_shadow;
        logic [3:0]   old_pend;
        xfer = valid & m_ready;
        trig = xfer[0] && cin[10];
        in_sr = (m_sr_left > 0);
        old_shadow = m_shadow;
        old_pend = m_pend;
        m_upd0 = '0;
        m_upd1 = '0;
        for (int i = 0; i < 4; i++) begin
            if (in_sr || trig || xfer[i]) m_ready[i] = 1'b0;
            else if (valid[i]) m_ready[i] = 1'b1;
            if (xfer[i]) begin
                m_out0[i*32 +: 32] = stored(i, cin[i*32 +: 32]);
                m_upd0[i] = 1'b1;
            end
            if (commit && old_pend[i]) begin
                m_out1[i*32 +: 32] = old_shadow[i*32 +: 32];
                m_upd1[i] = 1'b1;
                m_pend[i] = 1'b0;
            end
            if (xfer[i]) begin
                m_shadow[i*32 +: 32] = stored(i, cin[i*32 +: 32]);
                m_pend[i] = 1'b1;
            end
        end
        if (trig) m_sr_left = SR_LEN;
        else if (m_sr_left > 0) m_sr_left--;
    endtask

    task automatic compare_all();
        check("ready0", {124'd0, ready0}, {124'd0, m_ready});
        check("ready1", {124'd0, ready1}, {124'd0, m_ready});
        check("out0", out0, m_out0);
        check("out1", out1, m_out1);
        check("upd0", {124'd0, upd0}, {124'd0, m_upd0});
        check("upd1", {124'd0, upd1}, {124'd0, m_upd1});
        check("pend0", {124'd0, pend0}, 128'd0);
        check("pend1", {124'd0, pend1}, {124'd0, m_pend});
        check("sr0", {127'd0, sr0}, {127'd0, m_sr_left > 0});
        check("sr1", {127'd0, sr1}, {127'd0, m_sr_left > 0});
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset_n) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    // Hold valid until the model says the handshake completed on an edge.
    task automatic do_transfer(input int ch, input logic [31:0] d);
        logic done;
        logic will;
        done = 1'b0;
        valid[ch] = 1'b1;
        cin[ch*32 +: 32] = d;
        for (int g = 0; g < 40 && !done; g++) begin
            will = m_ready[ch];
            tick();
            if (will) done = 1'b1;
        end
        valid[ch] = 1'b0;
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL transfer_timeout ch=%0d actual=no_transfer expected=transfer", ch);
        end
    endtask

    task automatic wait_sr_done();
        for (int g = 0; g < 30 && m_sr_left > 0; g++) tick();
        checks++;
        if (m_sr_left > 0) begin
            errors++;
            $display("FAIL sr_timeout actual=%0d expected=0", m_sr_left);
        end
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rv_v = RV_P;
        wm_v = WM_P;
        vecs[0] = '{1, 32'hFFFF_FFFF, 32'hFFFF_1234};
        vecs[1] = '{2, 32'h0000_0055, 32'h0000_0055};
        vecs[2] = '{3, 32'h1234_5678, 32'h1234_5678};
        vecs[3] = '{0, 32'h12FF_AB34, 32'h12FF_0034};
        vecs[4] = '{0, 32'h0000_FFFF, 32'h0000_00FF};
        vecs[5] = '{1, 32'h0000_0000, 32'h0000_1234};
        vecs[6] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[7] = '{1, 32'hABCD_5678, 32'hABCD_1234};

        // Reset values
        #2 reset_n = 1'b0;
        model_reset();
        tick();
        tick();
        check("rst_out0_w1", {96'd0, out0[63:32]}, 128'h1234);
        check("rst_out1_w1", {96'd0, out1[63:32]}, 128'h1234);
        check("rst_flags", {112'd0, ready0, upd0, pend1, sr0, sr1, 2'b00}, 128'd0);
        reset_n = 1'b1;
        tick();
        tick();
        check("rel_out0_w1", {96'd0, out0[63:32]}, 128'h1234);

        // Basic write: ready after one edge, transfer on the next
        valid[0] = 1'b1;
        cin[31:0] = 32'hDEAD_BEEF;
        tick();
        check("bw_ready", {127'd0, ready0[0]}, 128'd1);
        tick();
        valid[0] = 1'b0;
        check("bw_out0", {96'd0, out0[31:0]}, 128'hDEAD_00EF);
        check("bw_upd", {127'd0, upd0[0]}, 128'd1);
        check("bw_ready_drop", {127'd0, ready0[0]}, 128'd0);
        check("bw_sr", {127'd0, sr0}, 128'd1);
        check("bw_pend1", {127'd0, pend1[0]}, 128'd1);
        tick();
        check("bw_upd_one", {127'd0, upd0[0]}, 128'd0);
        wait_sr_done();
        pulse_commit();
        check("bw_out1", {96'd0, out1[31:0]}, 128'hDEAD_00EF);

        // Soft reset width and held-off valid
        do_transfer(0, 32'h0000_0400);
        check("sr_stored", {96'd0, out0[31:0]}, 128'd0);
        valid[0] = 1'b1;
        cin[31:0] = 32'h0000_0001;
        cnt = 0;
        for (int g = 0; g < 20 && sr0; g++) begin
            cnt++;
            check("sr_ready_low", {124'd0, ready0}, 128'd0);
            tick();
        end
        check("sr_len", 128'(cnt), 128'd5);
        check("sr_after_ready", {127'd0, ready0[0]}, 128'd0);
        tick();
        check("sr_resume_ready", {127'd0, ready0[0]}, 128'd1);
        tick();
        valid[0] = 1'b0;
        check("sr_resume_out", {96'd0, out0[31:0]}, 128'd1);
        pulse_commit();

        // Table of writes with mask/trigger-bit handling, then commit
        for (int v = 0; v < 8; v++) begin
            do_transfer(vecs[v].ch, vecs[v].data);
            wait_sr_done();
            check("tbl_out0", {96'd0, out0[vecs[v].ch*32 +: 32]}, {96'd0, vecs[v].expect_word});
            check("tbl_pend", {127'd0, pend1[vecs[v].ch]}, 128'd1);
            pulse_commit();
            check("tbl_upd1", {127'd0, upd1[vecs[v].ch]}, 128'd1);
            check("tbl_out1", {96'd0, out1[vecs[v].ch*32 +: 32]}, {96'd0, vecs[v].expect_word});
            check("tbl_pend_clr", {127'd0, pend1[vecs[v].ch]}, 128'd0);
        end

        // Commit with nothing pending
        pulse_commit();
        check("idle_commit_upd", {124'd0, upd1}, 128'd0);

        // Transfer and commit on the same edge
        do_transfer(3, 32'h0000_0011);
        check("sim_pend", {127'd0, pend1[3]}, 128'd1);
        valid[3] = 1'b1;
        cin[127:96] = 32'h0000_0022;
        tick();
        check("sim_ready", {127'd0, ready1[3]}, 128'd1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        valid[3] = 1'b0;
        check("sim_out_old", {96'd0, out1[127:96]}, 128'h11);
        check("sim_pend_kept", {127'd0, pend1[3]}, 128'd1);
        tick();
        pulse_commit();
        check("sim_out_new", {96'd0, out1[127:96]}, 128'h22);
        check("sim_pend_clr", {127'd0, pend1[3]}, 128'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            valid = 4'($urandom);
            cin = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) != 0) cin[10] = 1'b0;
            commit = ($urandom_range(0, 3) == 0);
            tick();
        end
        valid = '0;
        commit = 1'b0;
        wait_sr_done();

        // Asynchronous reset in the middle of a soft-reset count with a pending shadow
        do_transfer(1, 32'hCAFE_0001);
        do_transfer(0, 32'h0000_0400);
        tick();
        tick();
        check("mid_pend", {127'd0, pend1[1]}, 128'd1);
        check("mid_sr", {127'd0, sr0}, 128'd1);
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        check("arst_sr", {126'd0, sr0, sr1}, 128'd0);
        check("arst_pend", {124'd0, pend1}, 128'd0);
        check("arst_out0", out0, RV_P);
        check("arst_out1", out1, RV_P);
        compare_all();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check("post_out1", out1, RV_P);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
